pipe_stage_skid: RTL

// - Parametrised inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) for the competition core.
// - Carries a control bundle plus a data payload, one cycle of latency.
// - Adds valid/ready flow control, a 2-entry skid option for full throughput with a registered in_ready,
//   and a synchronous flush that loads a bubble (no-op) control word.
// - Includes a saturating stall-cycle counter for performance tuning.

---
 rtl/pipe_pkg.sv | 76 +++++++
 rtl/pipe_stage_skid.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------------------------
// pipe_pkg
// Shared types for the inter-stage pipeline registers of the competition core.
//   - pipe_state_e       : occupancy state of a pipe_stage_skid instance (empty / main / main+skid)
//   - id_ex_ctrl_t       : ID/EX control bundle layout (WB, MEM, EX and competition fields)
//   - IdExCtrlBubble     : no-op control word for ID/EX; every write enable and memory strobe is 0
//   - state_occupancy()  : number of entries held in a given state
// ---------------------------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } pipe_state_e;

    // Field widths of the ID/EX control bundle.
    localparam int unsigned AluOpW    = 4;
    localparam int unsigned CompWeW   = 4;
    localparam int unsigned CompModeW = 6;
    localparam int unsigned CompTagW  = 8;

    typedef struct packed {
        // WB group
        logic                 reg_write;
        logic                 mem_to_reg;
        // MEM group
        logic                 mem_read;
        logic                 mem_write;
        logic                 branch;
        logic                 jump;
        // EX group
        logic                 reg_dst;
        logic                 alu_src;
        logic [AluOpW-1:0]    alu_op;
        logic                 shamt_sel;
        // Competition group
        logic                 sad_regfile_write;
        logic [CompWeW-1:0]   comp_we;
        logic [CompModeW-1:0] comp_mode;
        logic [CompTagW-1:0]  comp_tag;
    } id_ex_ctrl_t;

    localparam int unsigned IdExCtrlW = $bits(id_ex_ctrl_t);

    // A bubble must never write architectural state or touch memory; the remaining fields are
    // zeroed too so a bubble is easy to recognise in waveforms.
    localparam id_ex_ctrl_t IdExCtrlBubble = '{
        reg_write:         1'b0,
        mem_to_reg:        1'b0,
        mem_read:          1'b0,
        mem_write:         1'b0,
        branch:            1'b0,
        jump:              1'b0,
        reg_dst:           1'b0,
        alu_src:           1'b0,
        alu_op:            '0,
        shamt_sel:         1'b0,
        sad_regfile_write: 1'b0,
        comp_we:           '0,
        comp_mode:         '0,
        comp_tag:          '0
    };

    function automatic logic [1:0] state_occupancy(input pipe_state_e state);
        logic [1:0] occ;
        case (state)
            StEmpty: occ = 2'd0;
            StOne:   occ = 2'd1;
            StTwo:   occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------------------------
// pipe_stage_skid
// Inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) carrying a control bundle and a
// data payload with one cycle of latency, valid/ready flow control, an optional 2-entry skid
// buffer (registered in_ready, full throughput), a synchronous flush that turns the stage into a
// bubble, and a saturating stall-cycle counter.
//
// Parameters
//   DATA_W       payload width
//   CTRL_W       control bundle width
//   CTRL_BUBBLE  control value presented whenever out_valid is 0
//   SKID         1: main + skid entry, registered in_ready; 0: main only, combinational in_ready
//   CNT_W        width of stall_cnt
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous squash of every held entry
//   in_valid   in   upstream entry valid
//   in_ready   out  stage accepts an entry this cycle
//   in_ctrl    in   upstream control bundle
//   in_data    in   upstream payload
//   out_valid  out  main entry valid
//   out_ready  in   downstream accepts the main entry
//   out_ctrl   out  main control, CTRL_BUBBLE when out_valid is 0
//   out_data   out  main payload (stable unless a new entry is loaded into main)
//   occupancy  out  number of held entries, 0..2
//   stall_cnt  out  cycles with out_valid && !out_ready, saturating at all-ones
// ---------------------------------------------------------------------------------------------
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       CTRL_W      = 32,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
    parameter bit                SKID        = 1'b1,
    parameter int unsigned       CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;
    logic main_load;       // main takes a new entry this cycle
    logic main_from_skid;  // ...and that entry comes from the skid slot rather than the input
    logic skid_load;       // skid slot takes the input entry

    assign out_valid = (state_q != StEmpty);
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;

    // ------------------------------------------------------------------------------------------
    // Occupancy state machine
    // ------------------------------------------------------------------------------------------
    always_comb begin : next_state
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;

        // Flush wins over everything; an out_fire in this cycle has already been sampled
        // downstream, and an in_fire is simply dropped.
        if (flush) begin
            state_d = StEmpty;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d   = StOne;
                        main_load = 1'b1;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        main_load = 1'b1;
                    end else if (in_fire && SKID) begin
                        // Main is stalled, so the new entry parks behind it.
                        state_d   = StTwo;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    // in_ready is 0 here, so only the drain of main can happen.
                    if (out_fire) begin
                        state_d        = StOne;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = StEmpty;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------------------------
    // Entry registers
    // ------------------------------------------------------------------------------------------
    always_comb begin : entry_next
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Payloads are left as they are; only the control word is scrubbed.
            main_ctrl_d = CTRL_BUBBLE;
        end else if (main_load) begin
            if (main_from_skid) begin
                main_ctrl_d = skid_ctrl_q;
                main_data_d = skid_data_q;
            end else begin
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end
        end

        if (skid_load) begin
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
        end
    end

    // ------------------------------------------------------------------------------------------
    // Stall counter
    // ------------------------------------------------------------------------------------------
    always_comb begin : stall_next
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------------------------------
    // State flops
    // ------------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_ctrl_q <= CTRL_BUBBLE;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------------------------------
    // in_ready generation
    // ------------------------------------------------------------------------------------------
    if (SKID) begin : g_skid
        logic in_ready_q, in_ready_d;

        // The skid slot absorbs the one entry that can arrive while in_ready is still 1 from the
        // previous cycle, so in_ready only has to drop once both slots are full.
        assign in_ready_d = (state_d != StTwo);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= in_ready_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : g_no_skid
        // Main may be overwritten in the same cycle it drains.
        assign in_ready = ~out_valid | out_ready;
    end

    // ------------------------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------------------------
    assign out_ctrl  = out_valid ? main_ctrl_q : CTRL_BUBBLE;
    assign out_data  = main_data_q;
    assign occupancy = state_occupancy(state_q);
    assign stall_cnt = stall_cnt_q;

endmodule
